// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer and instruction-fetch controller.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   pc_cur           current PC fed back from the PC register
//   stall            blocks issue of a new fetch (never withdraws an issued one)
//   br_taken/br_target, jmp/jmp_target, trap
//                    redirect strobes, priority trap > jmp > branch
//   halt_req/resume  enter / leave the HALTED state
//   imem_ack         fetch completion from instruction memory
//   pc_new           next PC to the PC register (combinational)
//   imem_req/imem_addr  fetch request and address (address = pc_cur)
//   inst_valid       the instruction completing this cycle is architecturally valid
//   bus_err          one-cycle pulse when the fetch watchdog expires
//   epc              PC captured on trap or bus error
//   halted           controller is in HALTED
module pc_seq_ctrl #(
  parameter int unsigned            DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0]   RESET_PC  = 32'h0000_0000,
  parameter logic [DATAWIDTH-1:0]   TRAP_VEC  = 32'h0000_0100,
  parameter int unsigned            TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATAWIDTH-1:0] pc_cur,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [DATAWIDTH-1:0] br_target,
  input  logic                 jmp,
  input  logic [DATAWIDTH-1:0] jmp_target,
  input  logic                 trap,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 imem_ack,
  output logic [DATAWIDTH-1:0] pc_new,
  output logic                 imem_req,
  output logic [DATAWIDTH-1:0] imem_addr,
  output logic                 inst_valid,
  output logic                 bus_err,
  output logic [DATAWIDTH-1:0] epc,
  output logic                 halted
);

  localparam int unsigned    CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

  typedef enum logic {ST_FETCH, ST_HALTED} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_JMP, RD_TRAP} redir_t;

  state_t               r_state, w_state_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_pend_valid, w_pend_valid_nxt;
  redir_t               r_pend_kind, w_pend_kind_nxt;
  logic [DATAWIDTH-1:0] r_pend_target, w_pend_target_nxt;
  logic [CW-1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic [DATAWIDTH-1:0] r_epc, w_epc_nxt;

  logic                 w_req, w_done, w_wait, w_timeout;
  redir_t               w_in_kind, w_eff_kind;
  logic [DATAWIDTH-1:0] w_in_target, w_eff_target;
  logic                 w_take_in, w_eff_valid;
  logic [DATAWIDTH-1:0] w_pc_new;
  logic                 w_inst_valid, w_bus_err;

  assign w_req     = (r_state == ST_FETCH) & (r_busy | ~stall);
  assign w_done    = w_req & imem_ack;
  assign w_wait    = w_req & ~imem_ack;
  assign w_timeout = w_wait & (r_wait_cnt == LAST);

  // Arriving redirect, resolved by priority.
  always_comb begin
    w_in_kind   = RD_NONE;
    w_in_target = pc_cur;
    if (trap) begin
      w_in_kind   = RD_TRAP;
      w_in_target = TRAP_VEC;
    end else if (jmp) begin
      w_in_kind   = RD_JMP;
      w_in_target = jmp_target;
    end else if (br_taken) begin
      w_in_kind   = RD_BR;
      w_in_target = br_target;
    end
  end

  // A pending trap can only be replaced by another trap; otherwise the newest
  // redirect wins. The same rule merges a redirect arriving on the completion
  // cycle with one already pending.
  assign w_take_in    = (w_in_kind != RD_NONE) &
                        ~(r_pend_valid & (r_pend_kind == RD_TRAP) & (w_in_kind != RD_TRAP));
  assign w_eff_valid  = w_take_in | r_pend_valid;
  assign w_eff_kind   = w_take_in ? w_in_kind   : r_pend_kind;
  assign w_eff_target = w_take_in ? w_in_target : r_pend_target;

  always_comb begin
    w_state_nxt       = r_state;
    w_busy_nxt        = r_busy;
    w_pend_valid_nxt  = r_pend_valid;
    w_pend_kind_nxt   = r_pend_kind;
    w_pend_target_nxt = r_pend_target;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_epc_nxt         = r_epc;
    w_pc_new          = pc_cur;
    w_inst_valid      = 1'b0;
    w_bus_err         = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (w_timeout) begin
          w_pc_new         = TRAP_VEC;
          w_bus_err        = 1'b1;
          w_epc_nxt        = pc_cur;
          w_busy_nxt       = 1'b0;
          w_pend_valid_nxt = 1'b0;
          w_wait_cnt_nxt   = '0;
        end else if (w_wait) begin
          // Address must stay stable: hold the PC and park any redirect.
          w_busy_nxt     = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          if (w_take_in) begin
            w_pend_valid_nxt  = 1'b1;
            w_pend_kind_nxt   = w_in_kind;
            w_pend_target_nxt = w_in_target;
          end
        end else begin
          w_busy_nxt       = 1'b0;
          w_pend_valid_nxt = 1'b0;
          w_wait_cnt_nxt   = '0;
          if (w_eff_valid) begin
            w_pc_new = w_eff_target;
            if (w_eff_kind == RD_TRAP) w_epc_nxt = pc_cur;
          end else if (w_done) begin
            w_pc_new     = pc_cur + DATAWIDTH'(4);
            w_inst_valid = 1'b1;
          end
          if (halt_req) w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_busy_nxt       = 1'b0;
        w_pend_valid_nxt = 1'b0;
        w_wait_cnt_nxt   = '0;
        if (trap) begin
          w_pc_new    = TRAP_VEC;
          w_epc_nxt   = pc_cur;
          w_state_nxt = ST_FETCH;
        end else if (resume) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_busy        <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_kind   <= RD_NONE;
      r_pend_target <= '0;
      r_wait_cnt    <= '0;
      r_epc         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_busy        <= w_busy_nxt;
      r_pend_valid  <= w_pend_valid_nxt;
      r_pend_kind   <= w_pend_kind_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_epc         <= w_epc_nxt;
    end
  end

  assign pc_new     = rst_n ? w_pc_new : RESET_PC;
  assign imem_req   = rst_n & w_req;
  assign imem_addr  = pc_cur;
  assign inst_valid = rst_n & w_inst_valid;
  assign bus_err    = rst_n & w_bus_err;
  assign epc        = r_epc;
  assign halted     = (r_state == ST_HALTED);

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and instruction-fetch controller for the single-clock CPU.
- Drives pc_new into the PC register and receives the latched PC back as pc_cur.
- Runs a req/ack fetch handshake to instruction memory.
- Arbitrates the redirect sources, in priority order: trap, jump, branch.
- Handles stall, halt/resume and a fetch-timeout watchdog that vectors to the trap handler.

Parameters:
DATAWIDTH, 32, width of PC, targets and addresses
RESET_PC, 32'h0000_0000, value presented on pc_new while in reset
TRAP_VEC, 32'h0000_0100, trap/bus-error handler address
TIMEOUT, 16, max consecutive unacknowledged request cycles before bus error (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
pc_cur  in  DATAWIDTH  current PC from PC register
stall  in  1  blocks issue of a new fetch
br_taken  in  1  branch redirect strobe
br_target  in  DATAWIDTH  branch target
jmp  in  1  jump redirect strobe
jmp_target  in  DATAWIDTH  jump target
trap  in  1  exception strobe
halt_req  in  1  level, request halt
resume  in  1  leave HALTED
imem_ack  in  1  fetch complete
pc_new  out  DATAWIDTH  next PC to PC register (combinational)
imem_req  out  1  fetch request
imem_addr  out  DATAWIDTH  fetch address (= pc_cur)
inst_valid  out  1  fetched instruction is architecturally valid
bus_err  out  1  one-cycle pulse on fetch timeout
epc  out  DATAWIDTH  PC captured on trap or bus error
halted  out  1  state==HALTED

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values:
  - state=FETCH, busy=0, pend_valid=0, wait_cnt=0, epc=0, bus_err=0.
  - While rst_n=0, pc_new=RESET_PC and imem_req=0.
- States: FETCH and HALTED. busy=1 means a request has been issued and is not yet acked.
- Request and address:
  - imem_req = (state==FETCH) & (busy | ~stall).
  - imem_addr=pc_cur always.
  - Stall never withdraws an issued request.
- Handshake completes in a cycle with imem_req & imem_ack. busy sets in a cycle with imem_req & ~imem_ack and clears on completion.
- Default pc_new=pc_cur (hold). On completion with nothing pending or arriving: pc_new=pc_cur+4 (mod 2^DATAWIDTH), inst_valid=1.
- Redirect priority within a cycle: trap > jmp > br_taken.
- Redirect when no request is waiting (imem_req=0, or completion this cycle):
  - pc_new=target immediately.
  - Any instruction completing that cycle is squashed (inst_valid=0).
  - On trap: pc_new=TRAP_VEC and epc<=pc_cur.
- Redirect while waiting (imem_req=1, ack=0):
  - imem_addr must stay stable, so the redirect is latched into pend_valid/pend_kind/pend_target.
  - A later redirect overwrites the pending one, except that a pending trap is overwritten only by another trap.
  - At completion, pc_new=pend_target, inst_valid=0 and pend_valid clears. epc is captured at that point if the pending redirect is a trap.
- Watchdog:
  - wait_cnt increments each cycle with imem_req & ~imem_ack and clears on completion or on leaving FETCH.
  - If wait_cnt==TIMEOUT-1 and ack is still low:
    - bus_err=1 for that cycle only.
    - pc_new=TRAP_VEC, epc<=pc_cur.
    - busy, pend_valid and wait_cnt clear.
  - An ack arriving in that same cycle takes precedence: no bus error.
- Halt:
  - In FETCH with halt_req=1 and no waiting request, the next state is HALTED.
  - Any completing instruction still follows the normal completion rules; a redirect is applied before halting.
- HALTED:
  - imem_req=0, pc held.
  - resume -> FETCH.
  - trap -> pc_new=TRAP_VEC, epc<=pc_cur, FETCH. trap beats resume.
  - jmp/br_taken are ignored.
- Synchronous reset mid-request: busy, pending and counter clear. The memory must tolerate an abandoned request.

Test Plan:
1. Reset release, ack every cycle, stall=0 -> pc_new 0x0,0x4,0x8,0xC on successive cycles; inst_valid=1 each cycle.
2. At pc_cur=0x20, ack held low 3 cycles, jmp to 0x80 in wait cycle 1 -> imem_addr stays 0x20; at ack pc_new=0x80, inst_valid=0.
3. Simultaneous trap, jmp and br_taken with no request waiting at pc_cur=0x40 -> pc_new=0x100, epc=0x40.
4. TIMEOUT=16, ack never asserted at pc_cur=0x30 -> bus_err pulses in the 16th waiting cycle; pc_new=0x100, epc=0x30, no further pulse.
5. stall=1 with busy=0 -> imem_req=0, pc held. stall raised while busy=1 -> req stays high until ack, then drops.
6. halt_req at pc_cur=0x10 with ack -> halted=1 next cycle, PC 0x14 held. A jmp in HALTED is ignored. trap and resume together -> pc_new=0x100, back in FETCH.
